// File: rtl/alarm_mode_ctrl_if.sv
// Button/tick inputs and mode/display outputs of the alarm-clock mode controller.
// The master side is the button front-end (or bench); the slave side is the controller.
interface alarm_mode_ctrl_if;
  logic       tick_1hz;
  logic       btn_mode;
  logic       btn_up;
  logic       btn_down;
  logic [2:0] state;
  logic       inc;
  logic       dec;
  logic       modeDisp;
  logic       blink;
  logic       edit_active;

  modport master (
    output tick_1hz, btn_mode, btn_up, btn_down,
    input  state, inc, dec, modeDisp, blink, edit_active
  );

  modport slave (
    input  tick_1hz, btn_mode, btn_up, btn_down,
    output state, inc, dec, modeDisp, blink, edit_active
  );
endinterface

// File: rtl/alarm_mode_ctrl.sv
// Mode/edit controller for an alarm clock: cycles edit states on btn_mode, turns
// up/down buttons into inc/dec pulses or a 12/24h toggle, and times out idle edits.
module alarm_mode_ctrl #(
  parameter int TIMEOUT_S = 10
) (
  input logic               clk,
  input logic               reset_n,
  alarm_mode_ctrl_if.slave  io_ctl
);

  localparam logic [2:0] RUN         = 3'b000;
  localparam logic [2:0] SET_HR      = 3'b001;
  localparam logic [2:0] SET_MIN     = 3'b010;
  localparam logic [2:0] SET_ALM_HR  = 3'b011;
  localparam logic [2:0] SET_ALM_MIN = 3'b100;
  localparam logic [2:0] ALM_EN      = 3'b101;
  localparam logic [2:0] SET_FMT     = 3'b110;
  localparam logic [2:0] UNUSED      = 3'b111;

  localparam logic [5:0] TIMEOUT_V = 6'(TIMEOUT_S);

  logic [2:0] r_state;
  logic       r_inc;
  logic       r_dec;
  logic       r_fmt;
  logic       r_blink;
  logic [5:0] r_idle;

  logic [2:0] w_state_nxt;
  logic       w_edit;
  logic       w_field;
  logic       w_updn;
  logic       w_btn;
  logic       w_timeout;

  // Up and down together cancel each other, so only an exclusive press counts.
  always_comb begin
    w_edit    = (r_state != RUN);
    w_field   = (r_state >= SET_HR) && (r_state <= ALM_EN);
    w_updn    = io_ctl.btn_up ^ io_ctl.btn_down;
    w_btn     = io_ctl.btn_mode | w_updn;
    w_timeout = io_ctl.tick_1hz && w_edit && !w_btn &&
                ((r_idle + 6'd1) == TIMEOUT_V);
  end

  always_comb begin
    w_state_nxt = r_state;
    if (r_state == UNUSED) begin
      w_state_nxt = RUN;
    end else if (io_ctl.btn_mode) begin
      w_state_nxt = (r_state == SET_FMT) ? RUN : r_state + 3'd1;
    end else if (w_timeout) begin
      w_state_nxt = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= RUN;
      r_inc   <= 1'b0;
      r_dec   <= 1'b0;
      r_fmt   <= 1'b0;
      r_blink <= 1'b0;
      r_idle  <= 6'd0;
    end else begin
      r_state <= w_state_nxt;
      r_inc   <= w_field && !io_ctl.btn_mode && io_ctl.btn_up   && !io_ctl.btn_down;
      r_dec   <= w_field && !io_ctl.btn_mode && io_ctl.btn_down && !io_ctl.btn_up;

      if ((r_state == SET_FMT) && !io_ctl.btn_mode && w_updn) begin
        r_fmt <= ~r_fmt;
      end

      if ((w_state_nxt == RUN) || w_btn) begin
        r_idle <= 6'd0;
      end else if (io_ctl.tick_1hz && w_edit) begin
        r_idle <= r_idle + 6'd1;
      end

      // Field is shown solid right after any interaction, blinks at 1 Hz otherwise.
      if (w_state_nxt == RUN) begin
        r_blink <= 1'b0;
      end else if (w_btn) begin
        r_blink <= 1'b1;
      end else if (io_ctl.tick_1hz) begin
        r_blink <= ~r_blink;
      end
    end
  end

  assign io_ctl.state       = r_state;
  assign io_ctl.inc         = r_inc;
  assign io_ctl.dec         = r_dec;
  assign io_ctl.modeDisp    = r_fmt;
  assign io_ctl.blink       = r_blink;
  assign io_ctl.edit_active = w_edit;

endmodule

// File: tb/tb_alarm_mode_ctrl.sv
// Bench for alarm_mode_ctrl: directed scenarios then random traffic, all checked
// against a mode-index reference model every clock.
module tb_alarm_mode_ctrl;
  localparam int TO = 10;

  logic clk;
  logic reset_n;
  int   n_cmp;
  int   n_fail;

  alarm_mode_ctrl_if bus_if ();

  alarm_mode_ctrl #(.TIMEOUT_S(TO)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .io_ctl  (bus_if.slave)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // reference model: mode index 0..6 in the advance order, plus display bits
  int   m_mode;
  int   m_idle;
  logic m_fmt, m_inc, m_dec, m_blink;
  logic [7:0] exp_q[$];

  function automatic void model(input logic rst_n, input logic m, input logic u,
                                input logic d, input logic t);
    m_inc = 1'b0;
    m_dec = 1'b0;
    if (!rst_n) begin
      m_mode = 0; m_idle = 0; m_fmt = 1'b0; m_blink = 1'b0;
    end else if (m) begin
      m_mode  = (m_mode + 1) % 7;
      m_idle  = 0;
      m_blink = (m_mode != 0);
    end else if (u != d) begin
      if (m_mode >= 1 && m_mode <= 5) begin
        m_inc = u;
        m_dec = d;
      end
      if (m_mode == 6) m_fmt = ~m_fmt;
      m_idle  = 0;
      m_blink = (m_mode != 0);
    end else if (t && m_mode != 0) begin
      if (m_idle + 1 >= TO) begin
        m_mode = 0; m_idle = 0; m_blink = 1'b0;
      end else begin
        m_idle  = m_idle + 1;
        m_blink = ~m_blink;
      end
    end
  endfunction

  function automatic logic [7:0] model_vec();
    logic [2:0] st;
    st = 3'(m_mode);
    return {st, m_inc, m_dec, m_fmt, m_blink, (m_mode != 0)};
  endfunction

  // driver: one clock with the given inputs, then scoreboard check
  task automatic step(input logic rst_n, input logic m, input logic u,
                      input logic d, input logic t, input string tag);
    logic [7:0] obs;
    logic [7:0] exp_v;
    @(negedge clk);
    reset_n         = rst_n;
    bus_if.btn_mode = m;
    bus_if.btn_up   = u;
    bus_if.btn_down = d;
    bus_if.tick_1hz = t;
    model(rst_n, m, u, d, t);
    exp_q.push_back(model_vec());
    @(posedge clk);
    #1;
    reset_n         = 1'b1;
    bus_if.btn_mode = 1'b0;
    bus_if.btn_up   = 1'b0;
    bus_if.btn_down = 1'b0;
    bus_if.tick_1hz = 1'b0;
    obs   = {bus_if.state, bus_if.inc, bus_if.dec, bus_if.modeDisp,
             bus_if.blink, bus_if.edit_active};
    exp_v = exp_q.pop_front();
    n_cmp++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: {state,inc,dec,fmt,blink,edit} got %b expected %b",
             tag, obs, exp_v);
    end
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, tag);
  endtask

  task automatic tick(input string tag);
    step(1, 0, 0, 0, 1, tag);
    step(1, 0, 0, 0, 0, tag);
  endtask

  // independent constant check of selected outputs
  task automatic check_const(input logic [2:0] st, input logic fmt, input string tag);
    n_cmp++;
    assert ({bus_if.state, bus_if.modeDisp} === {st, fmt}) else begin
      n_fail++;
      $error("FAIL %s: state/fmt got %b/%b expected %b/%b",
             tag, bus_if.state, bus_if.modeDisp, st, fmt);
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    reset_n = 1'b0;
    bus_if.btn_mode = 1'b0;
    bus_if.btn_up   = 1'b0;
    bus_if.btn_down = 1'b0;
    bus_if.tick_1hz = 1'b0;
    m_mode = 0; m_idle = 0; m_fmt = 1'b0; m_inc = 1'b0; m_dec = 1'b0; m_blink = 1'b0;

    step(0, 0, 0, 0, 0, "reset");
    step(0, 1, 1, 0, 1, "reset_over_inputs");
    check_const(3'b000, 1'b0, "reset_const");

    // seven mode pulses walk the whole ring
    for (int i = 0; i < 7; i++) begin
      step(1, 1, 0, 0, 0, "mode_walk");
      idle(1, "mode_walk_hold");
    end
    check_const(3'b000, 1'b0, "mode_walk_end");

    // inc/dec pulses in SET_HR, cancelled when both pressed
    step(1, 1, 0, 0, 0, "to_set_hr");
    step(1, 0, 1, 0, 0, "up_inc");
    step(1, 0, 0, 0, 0, "inc_one_clk");
    step(1, 0, 0, 1, 0, "down_dec");
    step(1, 0, 0, 0, 0, "dec_one_clk");
    step(1, 0, 1, 1, 0, "up_down_ignored");
    idle(1, "after_both");

    // format toggle in SET_FMT survives the return to RUN
    for (int i = 0; i < 5; i++) step(1, 1, 0, 0, 0, "to_set_fmt");
    check_const(3'b110, 1'b0, "at_set_fmt");
    step(1, 0, 0, 1, 0, "fmt_toggle");
    check_const(3'b110, 1'b1, "fmt_now_24h");
    step(1, 1, 0, 0, 0, "fmt_to_run");
    step(1, 0, 1, 0, 0, "run_up_ignored");
    check_const(3'b000, 1'b1, "fmt_held_in_run");

    // plain timeout from SET_MIN
    step(1, 1, 0, 0, 0, "to_set_hr2");
    step(1, 1, 0, 0, 0, "to_set_min");
    for (int i = 0; i < TO - 1; i++) tick("timeout_count");
    step(1, 0, 0, 0, 1, "timeout_tick10");
    check_const(3'b000, 1'b1, "timed_out");

    // a button on the 9th tick restarts the count
    step(1, 1, 0, 0, 0, "to_set_hr3");
    step(1, 1, 0, 0, 0, "to_set_min2");
    for (int i = 0; i < TO - 2; i++) tick("restart_count");
    step(1, 0, 1, 0, 1, "button_on_tick9");
    idle(1, "restart_hold");
    tick("tick10_no_timeout");
    check_const(3'b010, 1'b1, "still_set_min");
    for (int i = 0; i < TO - 2; i++) tick("restart_count2");
    step(1, 0, 0, 0, 1, "restart_timeout");
    check_const(3'b000, 1'b1, "restart_timed_out");

    // mode wins over up in SET_ALM_HR
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0, "to_set_alm_hr");
    step(1, 1, 1, 0, 0, "mode_beats_up");
    check_const(3'b100, 1'b1, "at_set_alm_min");

    // reset during pending inc in ALM_EN
    step(1, 1, 0, 0, 0, "to_alm_en");
    step(1, 0, 1, 0, 0, "alm_en_inc");
    step(0, 0, 0, 0, 0, "reset_kills_inc");
    check_const(3'b000, 1'b0, "reset_clears_fmt");
    for (int i = 0; i < 5; i++) step(1, 1, 0, 0, 0, "to_alm_en2");
    step(0, 0, 1, 0, 1, "reset_with_up");

    // random traffic: sparse buttons so timeouts also occur
    for (int i = 0; i < 3000; i++) begin
      logic r, m, u, d, t;
      r = ($urandom_range(0, 399) != 0);
      m = ($urandom_range(0, 29) == 0);
      u = ($urandom_range(0, 24) == 0);
      d = ($urandom_range(0, 24) == 0);
      if (u && d) d = 1'b0;
      t = ($urandom_range(0, 3) == 0);
      step(r, m, u, d, t, "random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
